// File: rtl/prefetch_unit_if.sv
// prefetch_unit_if: redirect, instruction-delivery and instruction-memory
// handshake signals of the prefetch stage.
// master = prefetch unit side, slave = core / instruction memory side.
interface prefetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    input  redirect, redirect_addr, instr_ready, imem_gnt, imem_rvalid, imem_rdata,
    output instr, instr_pc, instr_valid, imem_req, imem_addr
  );

  modport slave (
    output redirect, redirect_addr, instr_ready, imem_gnt, imem_rvalid, imem_rdata,
    input  instr, instr_pc, instr_valid, imem_req, imem_addr
  );
endinterface

// File: rtl/prefetch_unit.sv
// prefetch_unit: sequential instruction prefetcher with a DEPTH-entry
// in-order queue. Requests are limited so that queued entries plus
// outstanding requests never exceed DEPTH, which guarantees room for every
// returning word. A redirect flushes the queue; responses that were granted
// before the redirect are counted as stale and dropped while in DRAIN.
// Optional feature macro: PREFETCH_BYPASS_EN (a response arriving at an
// empty queue is presented combinationally in the same cycle).
module prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  prefetch_unit_if.master bus
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW:0]   DEPTH_W  = DEPTH[CW:0];

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_n_s;
  logic [31:0]   fetch_addr_r;
  logic [31:0]   fetch_addr_n_s;
  logic [31:0]   resp_addr_r;     // address of the next non-stale response
  logic [31:0]   resp_addr_n_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_n_s;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] outstanding_n_s;
  logic [CW-1:0] stale_r;
  logic [CW-1:0] stale_n_s;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_ptr_n_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] wr_ptr_n_s;
  logic          req_ok_r;
  logic          req_ok_n_s;
  logic          instr_valid_r;
  logic [CW:0]   occupancy_n_s;
  logic [31:0]   redirect_target_s;
  logic [31:0]   q_data_r [DEPTH];
  logic [31:0]   q_pc_r   [DEPTH];

  logic grant_s;
  logic rvalid_any_s;
  logic rvalid_new_s;
  logic rvalid_stale_s;
  logic bypass_s;
  logic push_s;
  logic pop_s;

  // Classify this cycle's handshake events; stale responses always precede new ones.
  always_comb begin
    grant_s        = bus.imem_req & bus.imem_gnt;
    rvalid_stale_s = bus.imem_rvalid & (stale_r != CNT_ZERO);
    rvalid_new_s   = bus.imem_rvalid & (stale_r == CNT_ZERO) & (outstanding_r != CNT_ZERO);
    rvalid_any_s   = rvalid_stale_s | rvalid_new_s;
`ifdef PREFETCH_BYPASS_EN
    bypass_s       = rvalid_new_s & ~bus.redirect & (count_r == CNT_ZERO);
`else
    bypass_s       = 1'b0;
`endif
    push_s         = rvalid_new_s & ~bus.redirect & ~(bypass_s & bus.instr_ready);
    pop_s          = (count_r != CNT_ZERO) & bus.instr_ready & ~bus.redirect;
  end

  // Next fetch/response pointers, counters, queue pointers, FSM state and request enable.
  always_comb begin
    redirect_target_s = bus.redirect_addr & 32'hFFFF_FFFC;
    fetch_addr_n_s    = fetch_addr_r;
    resp_addr_n_s     = resp_addr_r;
    count_n_s         = count_r;
    outstanding_n_s   = outstanding_r;
    stale_n_s         = stale_r;
    rd_ptr_n_s        = rd_ptr_r;
    wr_ptr_n_s        = wr_ptr_r;
    if (bus.redirect) begin
      // In-flight new requests become stale; a response in this cycle is dropped.
      fetch_addr_n_s  = redirect_target_s;
      resp_addr_n_s   = redirect_target_s;
      count_n_s       = CNT_ZERO;
      outstanding_n_s = CNT_ZERO;
      stale_n_s       = stale_r + outstanding_r - (rvalid_any_s ? CNT_ONE : CNT_ZERO);
      rd_ptr_n_s      = PTR_ZERO;
      wr_ptr_n_s      = PTR_ZERO;
    end else begin
      fetch_addr_n_s  = fetch_addr_r + (grant_s ? 32'd4 : 32'd0);
      resp_addr_n_s   = resp_addr_r + (rvalid_new_s ? 32'd4 : 32'd0);
      count_n_s       = count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
      outstanding_n_s = outstanding_r + (grant_s ? CNT_ONE : CNT_ZERO)
                        - (rvalid_new_s ? CNT_ONE : CNT_ZERO);
      stale_n_s       = stale_r - (rvalid_stale_s ? CNT_ONE : CNT_ZERO);
      rd_ptr_n_s      = rd_ptr_r + (pop_s ? PTR_ONE : PTR_ZERO);
      wr_ptr_n_s      = wr_ptr_r + (push_s ? PTR_ONE : PTR_ZERO);
    end

    case (state_r)
      ST_FETCH: begin
        if (stale_n_s != CNT_ZERO) begin
          state_n_s = ST_DRAIN;
        end else begin
          state_n_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (stale_n_s == CNT_ZERO) begin
          state_n_s = ST_FETCH;
        end else begin
          state_n_s = ST_DRAIN;
        end
      end
      default: begin
        state_n_s = ST_FETCH;
      end
    endcase

    // Request only while the queue plus in-flight words leave room for one more.
    occupancy_n_s = {1'b0, count_n_s} + {1'b0, outstanding_n_s};
    req_ok_n_s    = (state_n_s == ST_FETCH) && (occupancy_n_s < DEPTH_W);
  end

  // State, counter and queue registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_FETCH;
      fetch_addr_r  <= RESET_PC;
      resp_addr_r   <= RESET_PC;
      count_r       <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      stale_r       <= CNT_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      req_ok_r      <= 1'b0;
      instr_valid_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data_r[i] <= 32'h0000_0000;
        q_pc_r[i]   <= 32'h0000_0000;
      end
    end else begin
      state_r       <= state_n_s;
      fetch_addr_r  <= fetch_addr_n_s;
      resp_addr_r   <= resp_addr_n_s;
      count_r       <= count_n_s;
      outstanding_r <= outstanding_n_s;
      stale_r       <= stale_n_s;
      rd_ptr_r      <= rd_ptr_n_s;
      wr_ptr_r      <= wr_ptr_n_s;
      req_ok_r      <= req_ok_n_s;
      instr_valid_r <= (count_n_s != CNT_ZERO);
      if (push_s) begin
        q_data_r[wr_ptr_r] <= bus.imem_rdata;
        q_pc_r[wr_ptr_r]   <= resp_addr_r;
      end
    end
  end

  // Present the queue head, or the live response when it bypasses an empty queue.
  always_comb begin
    if (bypass_s) begin
      bus.instr       = bus.imem_rdata;
      bus.instr_pc    = resp_addr_r;
      bus.instr_valid = 1'b1;
    end else begin
      bus.instr       = q_data_r[rd_ptr_r];
      bus.instr_pc    = q_pc_r[rd_ptr_r];
      bus.instr_valid = instr_valid_r;
    end
  end

  // A redirect suppresses the request in the same cycle, so no grant can race it.
  assign bus.imem_req  = req_ok_r & ~bus.redirect;
  assign bus.imem_addr = fetch_addr_r;

endmodule
